// File: rtl/mec_ppi_pkg.sv
// rtl/mec_ppi_pkg.sv - control word layout, mode/dir encodings and address offsets for mec_ppi_n
package mec_ppi_pkg;

    typedef enum logic {
        MODE_BASIC   = 1'b0,
        MODE_STROBED = 1'b1
    } ppi_mode_e;

    typedef enum logic {
        DIR_OUT = 1'b0,
        DIR_IN  = 1'b1
    } ppi_dir_e;

    localparam int CW_CFG_BIT  = 7;
    localparam int CW_PORT_LSB = 4;
    localparam int CW_PORT_W   = 3;
    localparam int CW_MODE_BIT = 1;
    localparam int CW_DIR_BIT  = 0;
    localparam int CW_INTE_BIT = 0;

    // Offsets of the non-data registers, relative to NPORTS.
    localparam int OFS_CTRL = 0;
    localparam int OFS_INTR = 1;
    localparam int OFS_OVR  = 2;

    function automatic logic is_fall(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

    function automatic logic is_rise(input logic prev, input logic cur);
        return ~prev & cur;
    endfunction

endpackage

// File: rtl/mec_ppi_port.sv
// rtl/mec_ppi_port.sv - one PPI port: latches, mode/dir/inte, handshake edge detect, Ibf/Obf_n/Intr/overrun
// MEC_PPI_SYNC_EN adds 2-flop synchronisers on pin, stb_n and ack_n.
module mec_ppi_port
    import mec_ppi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  ppi_mode_e        cfg_mode,
    input  ppi_dir_e         cfg_dir,
    input  logic             inte_we,
    input  logic             inte_val,
    input  logic             data_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_done,
    input  logic             ovr_clr,
    input  logic [WIDTH-1:0] pin,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic [WIDTH-1:0] pout,
    output logic             poe,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             ovr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] pin_s;
    logic             stb_s;
    logic             ack_s;

`ifdef MEC_PPI_SYNC_EN
    logic [WIDTH-1:0] pin_m;
    logic             stb_m;
    logic             ack_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_m <= '0;
            pin_s <= '0;
            stb_m <= 1'b1;
            stb_s <= 1'b1;
            ack_m <= 1'b1;
            ack_s <= 1'b1;
        end else begin
            pin_m <= pin;
            pin_s <= pin_m;
            stb_m <= stb_n;
            stb_s <= stb_m;
            ack_m <= ack_n;
            ack_s <= ack_m;
        end
    end
`else
    assign pin_s = pin;
    assign stb_s = stb_n;
    assign ack_s = ack_n;
`endif

    ppi_mode_e        mode;
    ppi_dir_e         dir;
    logic             inte;
    logic [WIDTH-1:0] latch;
    logic             stb_q;
    logic             ack_q;
    logic             stb_fall, stb_rise, ack_fall, ack_rise;
    logic             strobed_in;
    logic             ibf_eff;

    assign stb_fall   = is_fall(stb_q, stb_s);
    assign stb_rise   = is_rise(stb_q, stb_s);
    assign ack_fall   = is_fall(ack_q, ack_s);
    assign ack_rise   = is_rise(ack_q, ack_s);
    assign strobed_in = (mode == MODE_STROBED) && (dir == DIR_IN);
    // A completing read frees the buffer for a strobe landing in the same cycle.
    assign ibf_eff    = ibf & ~rd_done;

    always_ff @(posedge clk) begin
        // Edge history tracks through reset so a line held low is not seen as a fresh edge.
        stb_q <= stb_s;
        ack_q <= ack_s;
        if (reset) begin
            mode  <= MODE_BASIC;
            dir   <= DIR_IN;
            inte  <= 1'b0;
            pout  <= '0;
            poe   <= 1'b0;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
            ovr   <= 1'b0;
            latch <= '0;
        end else if (cfg_we) begin
            mode  <= cfg_mode;
            dir   <= cfg_dir;
            poe   <= (cfg_dir == DIR_OUT);
            inte  <= 1'b0;
            pout  <= '0;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
            ovr   <= 1'b0;
            latch <= '0;
        end else begin
            if (inte_we) begin
                inte <= inte_val;
            end
            if (ovr_clr) begin
                ovr <= 1'b0;
            end
            if (strobed_in) begin
                if (rd_done) begin
                    ibf  <= 1'b0;
                    intr <= 1'b0;
                end
                if (stb_fall) begin
                    if (ibf_eff) begin
                        ovr <= 1'b1;
                    end else begin
                        latch <= pin_s;
                        ibf   <= 1'b1;
                    end
                end
                if (stb_rise && ibf_eff && inte) begin
                    intr <= 1'b1;
                end
            end else if (dir == DIR_OUT) begin
                if (data_we) begin
                    pout <= wdata;
                    if (mode == MODE_STROBED) begin
                        obf_n <= 1'b0;
                        intr  <= 1'b0;
                    end
                end else if (mode == MODE_STROBED) begin
                    if (ack_fall) begin
                        obf_n <= 1'b1;
                    end
                    if (ack_rise && inte) begin
                        intr <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = pout;
        if (dir == DIR_IN) begin
            rdata = (mode == MODE_STROBED) ? latch : pin_s;
        end
    end

endmodule

// File: rtl/mec_ppi_n.sv
// rtl/mec_ppi_n.sv - NPORTS x WIDTH programmable peripheral interface on an 8085-style bus
// Optional MEC_PPI_SYNC_EN synchronises Pin/Stb_n/Ack_n inside each port.
module mec_ppi_n
    import mec_ppi_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int WIDTH  = 8,
    parameter int AW     = 3
) (
    input  logic                    Clk,
    input  logic                    Reset,
    inout  wire  [WIDTH-1:0]        d,
    input  logic [AW-1:0]           A,
    input  logic                    Cs_n,
    input  logic                    Rd_n,
    input  logic                    Wr_n,
    input  logic [NPORTS*WIDTH-1:0] Pin,
    output logic [NPORTS*WIDTH-1:0] Pout,
    output logic [NPORTS-1:0]       Poe,
    input  logic [NPORTS-1:0]       Stb_n,
    input  logic [NPORTS-1:0]       Ack_n,
    output logic [NPORTS-1:0]       Ibf,
    output logic [NPORTS-1:0]       Obf_n,
    output logic [NPORTS-1:0]       Intr
);

    localparam logic [AW-1:0] ADDR_CTRL = AW'(NPORTS + OFS_CTRL);
    localparam logic [AW-1:0] ADDR_INTR = AW'(NPORTS + OFS_INTR);
    localparam logic [AW-1:0] ADDR_OVR  = AW'(NPORTS + OFS_OVR);

    logic                 wr_strobe, rd_strobe;
    logic                 wr_prev, wr_commit;
    logic                 rd_block, rd_act, rd_prev, rd_done;
    logic [AW-1:0]        rd_addr;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rd_data;
    logic                 ctrl_we;
    logic [CW_PORT_W-1:0] cw_port;
    logic [WIDTH-1:0]     port_rdata [NPORTS];
    logic [NPORTS-1:0]    ovr_vec;

    assign wr_strobe = ~Cs_n & ~Wr_n;
    assign rd_strobe = ~Cs_n & ~Rd_n & Wr_n;
    assign wr_commit = wr_strobe & ~wr_prev;
    assign rd_act    = rd_strobe & ~rd_block;
    assign rd_done   = rd_prev & ~rd_strobe;
    assign wdata     = d;
    assign ctrl_we   = wr_commit && (A == ADDR_CTRL);
    assign cw_port   = wdata[CW_PORT_LSB +: CW_PORT_W];

    // Strobes still held from before reset are blocked until they are released.
    always_ff @(posedge Clk) begin
        wr_prev <= wr_strobe;
        if (Reset) begin
            rd_block <= rd_strobe;
            rd_prev  <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_block <= rd_block & rd_strobe;
            rd_prev  <= rd_act;
            if (rd_act) begin
                rd_addr <= A;
            end
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        mec_ppi_port #(
            .WIDTH(WIDTH)
        ) u_port (
            .clk      (Clk),
            .reset    (Reset),
            .cfg_we   (ctrl_we && wdata[CW_CFG_BIT] && (cw_port == CW_PORT_W'(k))),
            .cfg_mode (ppi_mode_e'(wdata[CW_MODE_BIT])),
            .cfg_dir  (ppi_dir_e'(wdata[CW_DIR_BIT])),
            .inte_we  (ctrl_we && !wdata[CW_CFG_BIT] && (cw_port == CW_PORT_W'(k))),
            .inte_val (wdata[CW_INTE_BIT]),
            .data_we  (wr_commit && (A == AW'(k))),
            .wdata    (wdata),
            .rd_done  (rd_done && (rd_addr == AW'(k))),
            .ovr_clr  (rd_done && (rd_addr == ADDR_OVR)),
            .pin      (Pin[k*WIDTH +: WIDTH]),
            .stb_n    (Stb_n[k]),
            .ack_n    (Ack_n[k]),
            .pout     (Pout[k*WIDTH +: WIDTH]),
            .poe      (Poe[k]),
            .ibf      (Ibf[k]),
            .obf_n    (Obf_n[k]),
            .intr     (Intr[k]),
            .ovr      (ovr_vec[k]),
            .rdata    (port_rdata[k])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (A == AW'(k)) begin
                rd_data = port_rdata[k];
            end
        end
        if (A == ADDR_INTR) begin
            rd_data[NPORTS-1:0] = Intr;
        end
        if (A == ADDR_OVR) begin
            rd_data[NPORTS-1:0] = ovr_vec;
        end
    end

    assign d = (rd_strobe && !Reset) ? rd_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mec_ppi_n.sv
// tb/tb_mec_ppi_n.sv - scoreboard bench for mec_ppi_n against a transaction-level port model
`timescale 1ns/1ps
module tb_mec_ppi_n;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int AW = 3;
`ifdef MEC_PPI_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int SEL_D = 0, SEL_POUT = 1, SEL_POE = 2, SEL_IBF = 3;
    localparam int SEL_OBF = 4, SEL_INTR = 5, SEL_MEAS = 6;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    wire  [W-1:0]   d;
    logic [AW-1:0]  A = '0;
    logic           Cs_n = 1'b1, Rd_n = 1'b1, Wr_n = 1'b1;
    logic [N*W-1:0] Pin = '0;
    wire  [N*W-1:0] Pout;
    wire  [N-1:0]   Poe, Ibf, Obf_n, Intr;
    logic [N-1:0]   Stb_n = '1, Ack_n = '1;
    logic           den = 1'b0;
    logic [W-1:0]   dv = '0;

    assign d = den ? dv : {W{1'bz}};
    always #5 Clk = ~Clk;

    mec_ppi_n #(.NPORTS(N), .WIDTH(W), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .d(d), .A(A), .Cs_n(Cs_n), .Rd_n(Rd_n), .Wr_n(Wr_n),
        .Pin(Pin), .Pout(Pout), .Poe(Poe), .Stb_n(Stb_n), .Ack_n(Ack_n),
        .Ibf(Ibf), .Obf_n(Obf_n), .Intr(Intr)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] mon_act;
    logic        obs_tick = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          meas = 0;

    // Reference model: per-port state changed one bus/handshake transaction at a time.
    logic         m_mode[N], m_dir[N], m_inte[N], m_ibf[N], m_obf[N], m_intr[N], m_ovr[N];
    logic [W-1:0] m_pout[N], m_latch[N], pin_v[N];

    always @(negedge Clk) begin
        if (obs_tick) begin
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                case (mon_e.sel)
                    SEL_D:    mon_act = 64'(d);
                    SEL_POUT: mon_act = 64'(Pout);
                    SEL_POE:  mon_act = 64'(Poe);
                    SEL_IBF:  mon_act = 64'(Ibf);
                    SEL_OBF:  mon_act = 64'(Obf_n);
                    SEL_INTR: mon_act = 64'(Intr);
                    default:  mon_act = 64'(meas);
                endcase
                total++;
                if (mon_act !== mon_e.val) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h want 0x%0h", mon_e.name, mon_act, mon_e.val);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clear_port(input int p);
        m_inte[p] = 0; m_ibf[p] = 0; m_obf[p] = 0; m_intr[p] = 0; m_ovr[p] = 0;
        m_pout[p] = '0; m_latch[p] = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            clear_port(k);
            m_mode[k] = 0;
            m_dir[k]  = 1;
        end
    endtask

    task automatic model_write(input int a, input logic [W-1:0] v);
        int p;
        p = int'(v[6:4]);
        if (a < N) begin
            if (!m_dir[a]) begin
                m_pout[a] = v;
                if (m_mode[a]) begin
                    m_obf[a]  = 1;
                    m_intr[a] = 0;
                end
            end
        end else if (a == N && p < N) begin
            if (v[7]) begin
                clear_port(p);
                m_mode[p] = v[1];
                m_dir[p]  = v[0];
            end else begin
                m_inte[p] = v[0];
            end
        end
    endtask

    function automatic logic [W-1:0] model_rd_val(input int a);
        logic [W-1:0] r;
        r = '0;
        if (a < N) begin
            if (!m_dir[a])      r = m_pout[a];
            else if (m_mode[a]) r = m_latch[a];
            else                r = pin_v[a];
        end else if (a == N + 1) begin
            for (int k = 0; k < N; k++) r[k] = m_intr[k];
        end else if (a == N + 2) begin
            for (int k = 0; k < N; k++) r[k] = m_ovr[k];
        end
        return r;
    endfunction

    task automatic model_rd_effects(input int a);
        if (a < N && m_dir[a] && m_mode[a]) begin
            m_ibf[a]  = 0;
            m_intr[a] = 0;
        end else if (a == N + 2) begin
            for (int k = 0; k < N; k++) m_ovr[k] = 0;
        end
    endtask

    task automatic model_stb(input int k);
        if (m_dir[k] && m_mode[k]) begin
            if (m_ibf[k]) m_ovr[k] = 1;
            else begin
                m_latch[k] = pin_v[k];
                m_ibf[k]   = 1;
            end
            if (m_inte[k]) m_intr[k] = 1;
        end
    endtask

    task automatic model_ack_fall(input int k);
        if (!m_dir[k] && m_mode[k]) m_obf[k] = 0;
    endtask

    task automatic model_ack_rise(input int k);
        if (!m_dir[k] && m_mode[k] && m_inte[k]) m_intr[k] = 1;
    endtask

    function automatic logic [63:0] exp_vec(input int sel);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            case (sel)
                SEL_POUT: r[k*W +: W] = m_pout[k];
                SEL_POE:  r[k] = ~m_dir[k];
                SEL_IBF:  r[k] = m_ibf[k];
                SEL_OBF:  r[k] = ~m_obf[k];
                default:  r[k] = m_intr[k];
            endcase
        end
        return r;
    endfunction

    task automatic check_status(input string tag);
        exp_q.push_back('{name: {tag, ".pout"}, sel: SEL_POUT, val: exp_vec(SEL_POUT)});
        exp_q.push_back('{name: {tag, ".poe"},  sel: SEL_POE,  val: exp_vec(SEL_POE)});
        exp_q.push_back('{name: {tag, ".ibf"},  sel: SEL_IBF,  val: exp_vec(SEL_IBF)});
        exp_q.push_back('{name: {tag, ".obf_n"}, sel: SEL_OBF, val: exp_vec(SEL_OBF)});
        exp_q.push_back('{name: {tag, ".intr"}, sel: SEL_INTR, val: exp_vec(SEL_INTR)});
        obs_tick = 1'b1;
        cyc(1);
        obs_tick = 1'b0;
    endtask

    task automatic bus_write(input int a, input logic [W-1:0] v, input int len);
        A = AW'(a); dv = v; den = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
        cyc(len);
        Cs_n = 1'b1; Wr_n = 1'b1; den = 1'b0;
        cyc(1);
        model_write(a, v);
    endtask

    task automatic bus_read(input int a, input string tag);
        exp_q.push_back('{name: tag, sel: SEL_D, val: 64'(model_rd_val(a))});
        A = AW'(a); Cs_n = 1'b0; Rd_n = 1'b0; obs_tick = 1'b1;
        cyc(1);
        obs_tick = 1'b0; Cs_n = 1'b1; Rd_n = 1'b1;
        cyc(1);
        model_rd_effects(a);
    endtask

    task automatic set_pin(input int k, input logic [W-1:0] v);
        Pin[k*W +: W] = v;
        pin_v[k] = v;
        cyc(LAT + 1);
    endtask

    task automatic stb_pulse(input int k, input logic [W-1:0] v, input int len);
        set_pin(k, v);
        Stb_n[k] = 1'b0;
        cyc(len);
        Stb_n[k] = 1'b1;
        cyc(LAT + 2);
        model_stb(k);
    endtask

    task automatic ack_pulse(input int k, input int len);
        Ack_n[k] = 1'b0;
        cyc(len + LAT + 1);
        model_ack_fall(k);
        Ack_n[k] = 1'b1;
        cyc(LAT + 2);
        model_ack_rise(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, p;
        logic [7:0] cw;
        for (int k = 0; k < N; k++) pin_v[k] = '0;
        model_reset();
        cyc(3);
        Reset = 1'b0;
        set_pin(1, 8'hA5);
        check_status("reset");
        bus_read(1, "rd_p1_default");

        bus_write(N, 8'h82, 1);
        bus_write(N, 8'h80, 1);
        bus_write(0, 8'h5A, 10);
        check_status("p0_out");
        bus_read(0, "rd_p0_out");

        bus_write(N, 8'hA3, 1);
        bus_write(N, 8'h21, 1);
        stb_pulse(2, 8'h3C, 2);
        check_status("p2_stb");
        bus_read(2, "rd_p2_3c");
        check_status("p2_after_rd");

        stb_pulse(2, 8'h3C, 1);
        stb_pulse(2, 8'h77, 1);
        bus_read(2, "rd_p2_keep");
        bus_read(N + 2, "rd_ovr_set");
        bus_read(N + 2, "rd_ovr_clr");

        bus_write(N, 8'h92, 1);
        bus_write(N, 8'h11, 1);
        bus_write(1, 8'h11, 1);
        check_status("p1_wr");
        Ack_n[1] = 1'b0;
        cyc(LAT + 1);
        model_ack_fall(1);
        check_status("p1_ack_lo");
        Ack_n[1] = 1'b1;
        cyc(LAT + 1);
        model_ack_rise(1);
        check_status("p1_ack_hi");
        bus_read(N + 1, "rd_intr_vec");

        // Ack_n fall and write commit land on the same edge: write wins.
        Ack_n[1] = 1'b0;
        cyc(LAT);
        A = 1; dv = 8'h33; den = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
        cyc(1);
        Cs_n = 1'b1; Wr_n = 1'b1; den = 1'b0;
        cyc(1);
        model_write(1, 8'h33);
        check_status("p1_wr_vs_ack");
        Ack_n[1] = 1'b1;
        cyc(LAT + 2);
        model_ack_rise(1);
        check_status("p1_ack_rel");

        // A 10-cycle write strobe with a full ack handshake inside it must commit once.
        A = 1; dv = 8'h22; den = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
        cyc(3);
        Ack_n[1] = 1'b0;
        cyc(2);
        Ack_n[1] = 1'b1;
        cyc(5);
        Cs_n = 1'b1; Wr_n = 1'b1; den = 1'b0;
        cyc(LAT + 2);
        model_write(1, 8'h22);
        model_ack_fall(1);
        model_ack_rise(1);
        check_status("p1_held_wr");

        set_pin(2, 8'hC9);
        Stb_n[2] = 1'b0;
        meas = 99;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (Ibf[2]) begin
                meas = i;
                break;
            end
        end
        exp_q.push_back('{name: "stb_to_ibf_latency", sel: SEL_MEAS, val: 64'(1 + LAT)});
        Stb_n[2] = 1'b1;
        cyc(LAT + 2);
        model_stb(2);
        check_status("p2_lat");

        bus_write(1, 8'h44, 1);
        A = AW'(N); dv = 8'h80; den = 1'b1; Cs_n = 1'b0; Wr_n = 1'b0;
        Reset = 1'b1;
        cyc(1);
        model_reset();
        check_status("reset_mid");
        Reset = 1'b0;
        cyc(2);
        Cs_n = 1'b1; Wr_n = 1'b1; den = 1'b0;
        cyc(1);
        check_status("reset_held_wr");
        bus_read(1, "rd_p1_after_reset");

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            p  = $urandom_range(0, N - 1);
            case (op)
                0: begin
                    cw = {1'b1, 3'($urandom_range(0, N)), 2'($urandom), 1'($urandom), 1'($urandom)};
                    bus_write(N, cw, $urandom_range(1, 3));
                end
                1: begin
                    cw = {1'b0, 3'(p), 3'($urandom), 1'($urandom)};
                    bus_write(N, cw, 1);
                end
                2: bus_write($urandom_range(0, 7), W'($urandom), $urandom_range(1, 4));
                3: bus_read($urandom_range(0, 7), "rd_rand");
                4: stb_pulse(p, W'($urandom), $urandom_range(1, 3));
                5: ack_pulse(p, $urandom_range(1, 3));
                default: set_pin(p, W'($urandom));
            endcase
            check_status("rand");
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expectations: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
